mem_arbiter: RTL and testbench

- Parametrised N-port memory arbiter that shares one memory port among several requesters, such as an I-cache and a D-cache, on the next-generation CPU.
- Every port, upstream and downstream, uses the CPU memory handshake: read/write held with address, data and mask stable until a one-cycle resp.
- The arbiter grants one requester at a time, forwards its transaction downstream and routes the response back.
- Round-robin or fixed-priority selection, chosen by parameter.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: handshake bundle between requesters, the arbiter and the shared memory port
// Requester side: req_read, req_write, req_address, req_wdata, req_byte_enable (to arbiter);
//                 req_rdata, req_resp (from arbiter).
// Memory side:    mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable (from arbiter);
//                 mem_rdata, mem_resp (to arbiter).
// Status:         busy, grant_id (from arbiter).
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    localparam int ID_WIDTH = $clog2(NUM_PORTS);
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS*MASK_WIDTH-1:0] req_byte_enable;
    logic [DATA_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            req_resp;
    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_address;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [MASK_WIDTH-1:0]           mem_byte_enable;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic                            mem_resp;
    logic                            busy;
    logic [ID_WIDTH-1:0]             grant_id;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, req_byte_enable, mem_rdata, mem_resp,
        output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
               busy, grant_id
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, req_byte_enable, mem_rdata, mem_resp,
        input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
               busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NUM_PORTS requesters, round-robin or fixed priority
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave) carrying the flattened
//        requester handshakes, the downstream memory handshake, busy and grant_id.
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int RR_MODE    = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_PORTS);
    localparam int SW  = IDW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_gid;
    logic [IDW-1:0]       r_ptr;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [IDW-1:0]       w_winner;
    logic                 w_found;
    logic                 w_busy;
    logic [SW-1:0]        w_idx;
    logic [NUM_PORTS-1:0] w_active;

    assign w_active = bus.req_read | bus.req_write;
    assign w_busy   = (r_state == BUSY);

    // Scan from lowest to highest priority so the last active hit is the winner.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_idx = (RR_MODE != 0) ? SW'(r_ptr) + SW'(k) : SW'(k);
            if (w_idx >= SW'(NUM_PORTS))
                w_idx = w_idx - SW'(NUM_PORTS);
            if (w_active[w_idx[IDW-1:0]]) begin
                w_winner = w_idx[IDW-1:0];
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gid       <= '0;
            r_ptr       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_state     <= BUSY;
                r_gid       <= w_winner;
                r_mem_write <= bus.req_write[w_winner];
                r_mem_read  <= ~bus.req_write[w_winner];
            end
        end else if (bus.mem_resp) begin
            // Strobes are held until completion even if the grantee drops its request.
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ptr       <= (r_gid == IDW'(NUM_PORTS - 1)) ? '0 : r_gid + 1'b1;
        end
    end

    assign bus.busy            = w_busy;
    assign bus.grant_id        = r_gid;
    assign bus.mem_read        = r_mem_read;
    assign bus.mem_write       = r_mem_write;
    assign bus.mem_address     = w_busy ? bus.req_address[r_gid*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.mem_wdata       = w_busy ? bus.req_wdata[r_gid*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.mem_byte_enable = w_busy ? bus.req_byte_enable[r_gid*MASK_WIDTH +: MASK_WIDTH] : '0;
    assign bus.req_rdata       = bus.mem_rdata;
    assign bus.req_resp        = (w_busy && bus.mem_resp) ? NUM_PORTS'(1) << r_gid : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin and fixed-priority arbiters checked against a transaction-level model
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]    rd     [2];
    logic [N-1:0]    wr     [2];
    logic [N*AW-1:0] addr   [2];
    logic [N*DW-1:0] data   [2];
    logic [N*MW-1:0] be     [2];
    logic [DW-1:0]   mrdata [2];
    logic            mresp  [2];

    wire [DW-1:0] o_rdata [2];
    wire [N-1:0]  o_resp  [2];
    wire          o_mr    [2];
    wire          o_mw    [2];
    wire [AW-1:0] o_ma    [2];
    wire [DW-1:0] o_mwd   [2];
    wire [MW-1:0] o_mbe   [2];
    wire          o_busy  [2];
    wire [1:0]    o_gid   [2];

    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 is fixed priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();
        assign bus.req_read        = rd[g];
        assign bus.req_write       = wr[g];
        assign bus.req_address     = addr[g];
        assign bus.req_wdata       = data[g];
        assign bus.req_byte_enable = be[g];
        assign bus.mem_rdata       = mrdata[g];
        assign bus.mem_resp        = mresp[g];
        assign o_rdata[g]          = bus.req_rdata;
        assign o_resp[g]           = bus.req_resp;
        assign o_mr[g]             = bus.mem_read;
        assign o_mw[g]             = bus.mem_write;
        assign o_ma[g]             = bus.mem_address;
        assign o_mwd[g]            = bus.mem_wdata;
        assign o_mbe[g]            = bus.mem_byte_enable;
        assign o_busy[g]           = bus.busy;
        assign o_gid[g]            = bus.grant_id;
        mem_arbiter #(
            .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
            .RR_MODE(g == 0 ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .reset(rst),
            .bus(bus)
        );
    end

    int vec = 0;
    int bad = 0;

    // Model: is a transaction in flight, who owns it, is it a write, and the round-robin pointer.
    bit          mb   [2];
    int          mg   [2];
    int          mp   [2];
    bit          mop  [2];
    logic [N-1:0] seen [2];

    task automatic chk(string n, int d, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", n, d, act, exp, $time);
        end
    endtask

    function automatic int pick(int d);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (d == 0) ? (mp[d] + k) % N : k;
            if (rd[d][i] || wr[d][i])
                return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] er;
            int w;
            if (rst) begin
                mb[d]  = 1'b0;
                mg[d]  = 0;
                mp[d]  = 0;
                mop[d] = 1'b0;
            end
            er = (mb[d] && mresp[d]) ? N'(1) << mg[d] : '0;
            chk("busy", d, o_busy[d], mb[d]);
            chk("grant_id", d, o_gid[d], mg[d]);
            chk("mem_read", d, o_mr[d], mb[d] && !mop[d]);
            chk("mem_write", d, o_mw[d], mb[d] && mop[d]);
            chk("mem_address", d, o_ma[d], mb[d] ? addr[d][mg[d]*AW +: AW] : 0);
            chk("mem_wdata", d, o_mwd[d], mb[d] ? data[d][mg[d]*DW +: DW] : 0);
            chk("mem_byte_enable", d, o_mbe[d], mb[d] ? be[d][mg[d]*MW +: MW] : 0);
            chk("req_rdata", d, o_rdata[d], mrdata[d]);
            chk("req_resp", d, o_resp[d], er);
            seen[d] = er;
            if (!rst) begin
                if (mb[d]) begin
                    if (mresp[d]) begin
                        mb[d] = 1'b0;
                        mp[d] = (mg[d] + 1) % N;
                    end
                end else begin
                    w = pick(d);
                    if (w >= 0) begin
                        mb[d]  = 1'b1;
                        mg[d]  = w;
                        mop[d] = wr[d][w];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(int d, int p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] dt, logic [MW-1:0] b);
        rd[d][p] = r;
        wr[d][p] = w;
        addr[d][p*AW +: AW] = a;
        data[d][p*DW +: DW] = dt;
        be[d][p*MW +: MW] = b;
    endtask

    task automatic setall(int p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] dt, logic [MW-1:0] b);
        for (int d = 0; d < 2; d++) setp(d, p, r, w, a, dt, b);
    endtask

    task automatic resp_all(bit v, logic [DW-1:0] dt);
        for (int d = 0; d < 2; d++) begin
            mresp[d]  = v;
            mrdata[d] = dt;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd[d] = '0; wr[d] = '0; addr[d] = '0; data[d] = '0; be[d] = '0;
            mrdata[d] = '0; mresp[d] = 1'b0; seen[d] = '0;
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk("lit_reset_busy", d, o_busy[d], 0);
            chk("lit_reset_gid", d, o_gid[d], 0);
        end
        rst = 1'b0;
        step();
        // Single read from port 1, completed three cycles after the grant.
        setall(1, 1, 0, 16'h1234, 16'h0, 2'b00);
        step();
        for (int d = 0; d < 2; d++) begin
            chk("lit_single_read", d, o_mr[d], 1);
            chk("lit_single_addr", d, o_ma[d], 16'h1234);
            chk("lit_single_gid", d, o_gid[d], 1);
        end
        step();
        step();
        resp_all(1'b1, 16'hBEEF);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("lit_single_resp", d, o_resp[d], 4'b0010);
            chk("lit_single_rdata", d, o_rdata[d], 16'hBEEF);
        end
        step();
        resp_all(1'b0, 16'h0);
        setall(1, 0, 0, 16'h0, 16'h0, 2'b00);
        #1;
        for (int d = 0; d < 2; d++) chk("lit_single_idle", d, o_busy[d], 0);
        // Read and write together are forwarded as a write.
        setall(0, 1, 1, 16'h0200, 16'h00AA, 2'b01);
        step();
        for (int d = 0; d < 2; d++) begin
            chk("lit_wr_write", d, o_mw[d], 1);
            chk("lit_wr_read", d, o_mr[d], 0);
            chk("lit_wr_addr", d, o_ma[d], 16'h0200);
            chk("lit_wr_data", d, o_mwd[d], 16'h00AA);
            chk("lit_wr_be", d, o_mbe[d], 2'b01);
        end
        resp_all(1'b1, 16'h0);
        step();
        resp_all(1'b0, 16'h0);
        setall(0, 0, 0, 16'h0, 16'h0, 2'b00);
        // Completing on port 2 leaves the round-robin pointer at 3.
        setall(2, 1, 0, 16'h2222, 16'h0, 2'b00);
        step();
        resp_all(1'b1, 16'h0);
        step();
        resp_all(1'b0, 16'h0);
        setall(2, 0, 0, 16'h0, 16'h0, 2'b00);
        // Ports 0 and 3 held: round-robin wraps 3 then 0, fixed priority keeps 0.
        setall(0, 1, 0, 16'h0A0A, 16'h0, 2'b00);
        setall(3, 1, 0, 16'h3B3B, 16'h0, 2'b00);
        step();
        chk("lit_wrap_rr_first", 0, o_gid[0], 3);
        chk("lit_wrap_fp_first", 1, o_gid[1], 0);
        resp_all(1'b1, 16'h0);
        step();
        resp_all(1'b0, 16'h0);
        #1;
        for (int d = 0; d < 2; d++) chk("lit_bubble", d, o_busy[d], 0);
        step();
        chk("lit_wrap_rr_second", 0, o_gid[0], 0);
        chk("lit_wrap_fp_second", 1, o_gid[1], 0);
        resp_all(1'b1, 16'h0);
        step();
        resp_all(1'b0, 16'h0);
        setall(0, 0, 0, 16'h0, 16'h0, 2'b00);
        step();
        for (int d = 0; d < 2; d++) chk("lit_after_drop_gid", d, o_gid[d], 3);
        // Asynchronous reset in the middle of the port 3 read.
        setall(1, 1, 0, 16'h1111, 16'h0, 2'b00);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("lit_rst_busy", d, o_busy[d], 0);
            chk("lit_rst_gid", d, o_gid[d], 0);
            chk("lit_rst_read", d, o_mr[d], 0);
        end
        step();
        setall(3, 0, 0, 16'h0, 16'h0, 2'b00);
        rst = 1'b0;
        step();
        for (int d = 0; d < 2; d++) chk("lit_rst_regrant", d, o_gid[d], 1);
        resp_all(1'b1, 16'h0);
        step();
        resp_all(1'b0, 16'h0);
        setall(1, 0, 0, 16'h0, 16'h0, 2'b00);
        step();
        // Random traffic: requesters hold until their response, occasionally drop early.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int d = 0; d < 2; d++) begin
                mrdata[d] = DW'($urandom);
                mresp[d]  = mb[d] && ($urandom_range(0, 2) == 0);
                for (int p = 0; p < N; p++) begin
                    int op;
                    if (seen[d][p]) begin
                        rd[d][p] = 1'b0;
                        wr[d][p] = 1'b0;
                    end else if (!(rd[d][p] || wr[d][p])) begin
                        if ($urandom_range(0, 3) == 0) begin
                            op = $urandom_range(0, 2);
                            setp(d, p, op != 1, op != 0, AW'($urandom), DW'($urandom), MW'($urandom));
                        end
                    end else if ($urandom_range(0, 99) == 0) begin
                        rd[d][p] = 1'b0;
                        wr[d][p] = 1'b0;
                    end
                end
            end
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
